// File: rtl/bw_filter_pkg.sv
// Shared types and luma helper for the black/white filter frame sequencer.
package bw_filter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  localparam logic [7:0] LUMA_R = 8'd77;
  localparam logic [7:0] LUMA_G = 8'd150;
  localparam logic [7:0] LUMA_B = 8'd29;

  // Weights sum to 256, so the 16-bit sum peaks at 65280 and cannot wrap.
  function automatic logic [7:0] luma(input logic [23:0] rgb);
    logic [15:0] w_sum;
    w_sum = ({8'd0, LUMA_R} * {8'd0, rgb[23:16]})
          + ({8'd0, LUMA_G} * {8'd0, rgb[15:8]})
          + ({8'd0, LUMA_B} * {8'd0, rgb[7:0]});
    return w_sum[15:8];
  endfunction

endpackage

// File: rtl/bw_filter_core.sv
// Combinational luma and threshold compare for one RGB888 pixel.
module bw_filter_core
  import bw_filter_pkg::*;
#(
  parameter int PIX_W = 24,
  parameter int OUT_W = 8
) (
  input  logic [PIX_W-1:0] i_pix,
  input  logic [7:0]       i_thr,
  output logic [OUT_W-1:0] o_pix
);

  logic [7:0] w_y;

  // Luma of the incoming pixel, then binarise against the threshold.
  always_comb begin
    w_y = luma(i_pix);
    if (w_y >= i_thr) begin
      o_pix = {OUT_W{1'b1}};
    end else begin
      o_pix = {OUT_W{1'b0}};
    end
  end

endmodule

// File: rtl/bw_filter_frame_seq.sv
// Frame sequencer: latches config on start, streams width*height pixels through the core.
// Optional BW_FILTER_SEQ_PERF_EN adds the saturating output-stall counter sts_stall_cnt.
module bw_filter_frame_seq
  import bw_filter_pkg::*;
#(
  parameter int DIM_W = 12,
  parameter int PIX_W = 24,
  parameter int OUT_W = 8
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             cfg_start,
  input  logic             cfg_abort,
  input  logic [DIM_W-1:0] cfg_width,
  input  logic [DIM_W-1:0] cfg_height,
  input  logic [7:0]       cfg_threshold,
  input  logic [PIX_W-1:0] s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic [OUT_W-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             m_tuser,
  output logic             sts_busy,
  output logic             sts_done,
  output logic             sts_err,
  output logic             sts_aborted
`ifdef BW_FILTER_SEQ_PERF_EN
  ,
  output logic [31:0]      sts_stall_cnt
`endif
);

  localparam logic [DIM_W-1:0] DIM_ZERO = {DIM_W{1'b0}};
  localparam logic [DIM_W-1:0] DIM_ONE  = DIM_W'(1);

  seq_state_e       r_state;
  seq_state_e       w_next;
  logic [DIM_W-1:0] r_width;
  logic [DIM_W-1:0] r_height;
  logic [DIM_W-1:0] r_col;
  logic [DIM_W-1:0] r_row;
  logic [7:0]       r_thr;
  logic [OUT_W-1:0] r_m_tdata;
  logic             r_m_tvalid;
  logic             r_m_tlast;
  logic             r_m_tuser;
  logic             r_done;
  logic             r_err;
  logic             r_aborted;

  logic [OUT_W-1:0] w_core_pix;
  logic             w_s_tready;
  logic             w_busy;
  logic             w_start_ok;
  logic             w_accept;
  logic             w_col_last;
  logic             w_row_last;
  logic             w_frame_last;
  logic             w_m_hs;

  bw_filter_core #(
    .PIX_W (PIX_W),
    .OUT_W (OUT_W)
  ) u_core (
    .i_pix (s_tdata),
    .i_thr (r_thr),
    .o_pix (w_core_pix)
  );

  assign w_start_ok   = cfg_start && (cfg_width != DIM_ZERO) && (cfg_height != DIM_ZERO);
  assign w_accept     = s_tvalid && w_s_tready;
  assign w_col_last   = (r_col == (r_width - DIM_ONE));
  assign w_row_last   = (r_row == (r_height - DIM_ONE));
  assign w_frame_last = w_accept && w_col_last && w_row_last;
  assign w_m_hs       = r_m_tvalid && m_tready;

  // State register.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state; abort outranks both start and the last-pixel accept.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start_ok) w_next = RUN; else w_next = IDLE;
      RUN:     if (cfg_abort) w_next = IDLE; else if (w_frame_last) w_next = DRAIN; else w_next = RUN;
      DRAIN:   if (cfg_abort) w_next = IDLE; else if (w_m_hs) w_next = DONE; else w_next = DRAIN;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    w_s_tready = 1'b0;
    w_busy     = 1'b0;
    case (r_state)
      RUN: begin
        w_s_tready = !r_m_tvalid || m_tready;
        w_busy     = 1'b1;
      end
      DRAIN:   w_busy = 1'b1;
      default: w_busy = 1'b0;
    endcase
  end

  // Config latch, counters, output register and sticky status.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_width    <= DIM_ZERO;
      r_height   <= DIM_ZERO;
      r_col      <= DIM_ZERO;
      r_row      <= DIM_ZERO;
      r_thr      <= 8'd0;
      r_m_tdata  <= {OUT_W{1'b0}};
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tuser  <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_aborted  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start_ok) begin
            r_width   <= cfg_width;
            r_height  <= cfg_height;
            r_thr     <= cfg_threshold;
            r_col     <= DIM_ZERO;
            r_row     <= DIM_ZERO;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_aborted <= 1'b0;
          end else if (cfg_start) begin
            r_err     <= 1'b1;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
          end
        end
        RUN, DRAIN: begin
          if (cfg_abort) begin
            r_m_tvalid <= 1'b0;
            r_aborted  <= 1'b1;
          end else if (w_accept) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= w_core_pix;
            r_m_tlast  <= w_col_last;
            r_m_tuser  <= (r_col == DIM_ZERO) && (r_row == DIM_ZERO);
            if (w_col_last) begin
              r_col <= DIM_ZERO;
              r_row <= w_row_last ? DIM_ZERO : (r_row + DIM_ONE);
            end else begin
              r_col <= r_col + DIM_ONE;
            end
          end else if (w_m_hs) begin
            r_m_tvalid <= 1'b0;
          end
        end
        DONE:    r_done <= 1'b1;
        default: r_m_tvalid <= 1'b0;
      endcase
    end
  end

`ifdef BW_FILTER_SEQ_PERF_EN
  logic [31:0] r_stall_cnt;

  // Saturating count of busy cycles with a stalled output.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_stall_cnt <= 32'd0;
    end else if ((r_state == IDLE) && w_start_ok) begin
      r_stall_cnt <= 32'd0;
    end else if (w_busy && r_m_tvalid && !m_tready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign sts_stall_cnt = r_stall_cnt;
`endif

  assign s_tready    = w_s_tready;
  assign sts_busy    = w_busy;
  assign m_tdata     = r_m_tdata;
  assign m_tvalid    = r_m_tvalid;
  assign m_tlast     = r_m_tlast;
  assign m_tuser     = r_m_tuser;
  assign sts_done    = r_done;
  assign sts_err     = r_err;
  assign sts_aborted = r_aborted;

endmodule

// File: tb/tb_bw_filter_frame_seq.sv
// Self-checking bench for bw_filter_frame_seq: luma vector table, random frames vs a frame model, corner sequences.
module tb_bw_filter_frame_seq;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        cfg_start = 1'b0;
  logic        cfg_abort = 1'b0;
  logic [11:0] cfg_width = 12'd0;
  logic [11:0] cfg_height = 12'd0;
  logic [7:0]  cfg_threshold = 8'd0;
  logic [23:0] s_tdata = 24'd0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic        m_tuser;
  logic        sts_busy;
  logic        sts_done;
  logic        sts_err;
  logic        sts_aborted;
`ifdef BW_FILTER_SEQ_PERF_EN
  logic [31:0] sts_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [9:0] obs_q[$];

  bw_filter_frame_seq dut (
    .ACLK(ACLK), .ARESET(ARESET), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_threshold(cfg_threshold),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tuser(m_tuser), .sts_busy(sts_busy), .sts_done(sts_done),
    .sts_err(sts_err), .sts_aborted(sts_aborted)
`ifdef BW_FILTER_SEQ_PERF_EN
    , .sts_stall_cnt(sts_stall_cnt)
`endif
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [23:0] pix;
    logic [7:0]  thr;
    logic [7:0]  exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic [7:0] ref_pix(input logic [23:0] p, input logic [7:0] thr);
    int r, g, b, y;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    y = (77 * r + 150 * g + 29 * b) / 256;
    return (y >= int'(thr)) ? 8'hFF : 8'h00;
  endfunction

  // stop_mode: 0 run to completion, 1 abort, 2 abort+start together, 3 ARESET; taken once stop_at pixels are accepted.
  task automatic run_frame(input int w, input int h, input logic [7:0] thr, input int fixed,
                           input logic [23:0] fpix, input int rdy_pct, input int stop_mode,
                           input int stop_at, input int poke);
    int n, sent, got, cyc, stall;
    logic [23:0] pix[$];
    logic [9:0]  exp_q[$];
    logic        prev_stall;
    logic [9:0]  prev_m;
    n = w * h; sent = 0; got = 0; cyc = 0; stall = 0; prev_stall = 1'b0; prev_m = 10'd0;
    obs_q.delete();
    for (int k = 0; k < n; k++) begin
      pix.push_back(fixed != 0 ? fpix : 24'($urandom));
      exp_q.push_back({ref_pix(pix[k], thr), (k % w) == (w - 1), k == 0});
    end
    cfg_width = 12'(w); cfg_height = 12'(h); cfg_threshold = thr; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    while (got < n && cyc < 2000) begin
      if (stop_mode != 0 && sent == stop_at) begin
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        if (stop_mode == 3) ARESET = 1'b1;
        else cfg_abort = 1'b1;
        cfg_start = (stop_mode == 2);
        tick();
        ARESET = 1'b0; cfg_abort = 1'b0; cfg_start = 1'b0;
        @(negedge ACLK);
        chk("stop_busy", 32'(sts_busy), 32'd0);
        chk("stop_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("stop_s_tready", 32'(s_tready), 32'd0);
        chk("stop_aborted", 32'(sts_aborted), (stop_mode == 3) ? 32'd0 : 32'd1);
        chk("stop_done", 32'(sts_done), 32'd0);
        if (stop_mode == 3) chk("reset_m_tdata", 32'({m_tdata, m_tlast, m_tuser}), 32'd0);
        tick();
        return;
      end
      s_tvalid = (sent < n) && ($urandom_range(0, 3) != 0);
      s_tdata  = (sent < n) ? pix[sent] : 24'd0;
      m_tready = ($urandom_range(1, 100) <= rdy_pct);
      cfg_start = (poke != 0 && cyc == 3);
      if (poke != 0 && cyc == 3) begin
        cfg_width = 12'd1; cfg_height = 12'd1;
      end
      @(negedge ACLK);
      if (prev_stall) chk("stall_hold", 32'({m_tvalid, m_tdata, m_tlast, m_tuser}), 32'({1'b1, prev_m}));
      prev_stall = m_tvalid && !m_tready;
      prev_m = {m_tdata, m_tlast, m_tuser};
      if (sts_busy && m_tvalid && !m_tready) stall++;
      if (s_tvalid && s_tready) sent++;
      if (m_tvalid && m_tready) begin
        obs_q.push_back({m_tdata, m_tlast, m_tuser});
        got++;
      end
      tick();
      cfg_start = 1'b0;
      cyc++;
    end
    s_tvalid = 1'b0;
    chk("out_count", 32'(got), 32'(n));
    for (int k = 0; k < got && k < n; k++) begin
      chk($sformatf("pix%0d_%0dx%0d", k, w, h), 32'(obs_q[k]), 32'(exp_q[k]));
    end
    for (int k = 0; k < 10 && !sts_done; k++) tick();
    chk("done_set", 32'(sts_done), 32'd1);
    chk("done_idle", 32'(sts_busy), 32'd0);
`ifdef BW_FILTER_SEQ_PERF_EN
    chk("stall_cnt", sts_stall_cnt, 32'(stall));
`endif
  endtask

  initial begin
    vec_t vecs[8];
    int   nlast;
    vecs[0] = '{24'h808080, 8'h80, 8'hFF};
    vecs[1] = '{24'h808080, 8'h81, 8'h00};
    vecs[2] = '{24'hFF0000, 8'h4D, 8'h00};
    vecs[3] = '{24'hFF0000, 8'h4C, 8'hFF};
    vecs[4] = '{24'hFF00FF, 8'h4C, 8'hFF};
    vecs[5] = '{24'h000000, 8'h00, 8'hFF};
    vecs[6] = '{24'hFFFFFF, 8'hFF, 8'hFF};
    vecs[7] = '{24'h00FF00, 8'h96, 8'h00};

    tick(); tick();
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    chk("rst_m_out", 32'({m_tvalid, m_tdata, m_tlast, m_tuser}), 32'd0);
    chk("rst_sts", 32'({sts_busy, sts_done, sts_err, sts_aborted}), 32'd0);
    tick();

    // 1x1 frames from the table: single pixel carries both SOF and end-of-line.
    for (int i = 0; i < 8; i++) begin
      run_frame(1, 1, vecs[i].thr, 1, vecs[i].pix, 100, 0, 0, 0);
      if (obs_q.size() > 0) chk($sformatf("vec%0d", i), 32'(obs_q[0]), 32'({vecs[i].exp, 1'b1, 1'b1}));
    end

    run_frame(4, 2, 8'h80, 1, 24'h808080, 100, 0, 0, 0);
    nlast = 0;
    foreach (obs_q[k]) if (obs_q[k][1]) nlast++;
    chk("t1_tlast_count", 32'(nlast), 32'd2);
    run_frame(4, 2, 8'h81, 1, 24'h808080, 100, 0, 0, 0);

    for (int i = 0; i < 3; i++) run_frame(3, 3, 8'($urandom), 0, 24'd0, 50, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      run_frame($urandom_range(1, 5), $urandom_range(1, 4), 8'($urandom), 0, 24'd0, 60, 0, 0, 0);
    run_frame(1, 4, 8'h40, 0, 24'd0, 50, 0, 0, 0);

    // Zero-dimension start flags an error and clears done; a valid start clears the error.
    cfg_width = 12'd0; cfg_height = 12'd2; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    @(negedge ACLK);
    chk("zero_err", 32'(sts_err), 32'd1);
    chk("zero_busy", 32'(sts_busy), 32'd0);
    chk("zero_done_clr", 32'(sts_done), 32'd0);
    tick();
    cfg_width = 12'd2; cfg_height = 12'd0; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("zero_h_err", 32'(sts_err), 32'd1);
    cfg_width = 12'd2; cfg_height = 12'd2; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    @(negedge ACLK);
    chk("restart_err_clr", 32'(sts_err), 32'd0);
    chk("restart_busy", 32'(sts_busy), 32'd1);
    tick();
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    chk("abort_idle_start", 32'({sts_busy, sts_aborted}), 32'b01);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    chk("abort_in_idle", 32'({sts_busy, sts_aborted, sts_err}), 32'b010);

    run_frame(4, 2, 8'h80, 0, 24'd0, 100, 1, 3, 0);
    run_frame(2, 2, 8'h80, 0, 24'd0, 100, 0, 0, 0);
    run_frame(3, 3, 8'h70, 0, 24'd0, 70, 0, 0, 1);
    run_frame(4, 2, 8'h80, 0, 24'd0, 100, 2, 2, 0);
    run_frame(1, 1, 8'h10, 0, 24'd0, 100, 0, 0, 0);
    run_frame(4, 3, 8'h80, 0, 24'd0, 80, 3, 5, 0);
    run_frame(3, 2, 8'h90, 0, 24'd0, 40, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
